// File: rtl/rr_bank_arbiter_if.sv
// Consumer request/grant/response and PLM command/read-data bundle for rr_bank_arbiter.
// Combinational grant is the only flow control: an ungranted request is held by the consumer.
interface rr_bank_arbiter_if #(
    parameter int ADDR_WIDTH  = 4,
    parameter int VALUE_WIDTH = 8,
    parameter int NCONSUMERS  = 4,
    parameter int NBANKS      = 2,
    parameter int NPORTS      = 2
);
    localparam int BANK_BITS       = (NBANKS > 1) ? $clog2(NBANKS) : 0;
    localparam int REQ_WIDTH       = ADDR_WIDTH + VALUE_WIDTH + 2;
    localparam int PLM_INPUT_WIDTH = ADDR_WIDTH - BANK_BITS + VALUE_WIDTH + 1;
    localparam int NKERNELS        = NBANKS * NPORTS;

    logic [NCONSUMERS-1:0][REQ_WIDTH-1:0]     requests;
    logic [NCONSUMERS-1:0]                    grant;
    logic [NKERNELS-1:0][PLM_INPUT_WIDTH-1:0] out;
    logic [NKERNELS-1:0]                      plm_en;
    logic [NKERNELS-1:0][VALUE_WIDTH-1:0]     plm_rdata;
    logic [NCONSUMERS-1:0]                    resp_valid;
    logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0]   resp_data;

    modport master (
        output requests, plm_rdata,
        input  grant, out, plm_en, resp_valid, resp_data
    );

    modport slave (
        input  requests, plm_rdata,
        output grant, out, plm_en, resp_valid, resp_data
    );
endinterface

// File: rtl/rr_bank_arbiter.sv
// Round-robin arbiter from NCONSUMERS requesters onto NBANKS x NPORTS PLM kernels with read-data return.
// Grant is same-cycle, PLM command 1 cycle later, read data 1+READ_LATENCY cycles after grant; no backpressure beyond holding ungranted requests.
module rr_bank_arbiter #(
    parameter int ADDR_WIDTH   = 4,
    parameter int VALUE_WIDTH  = 8,
    parameter int NCONSUMERS   = 4,
    parameter int NBANKS       = 2,
    parameter int NPORTS       = 2,
    parameter int READ_LATENCY = 1,
    parameter int PIVOT_MODE   = 1
) (
    input  logic             clk,
    input  logic             reset,
    rr_bank_arbiter_if.slave bus
);
    localparam int BANK_BITS = (NBANKS > 1) ? $clog2(NBANKS) : 0;
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int LOCAL_W   = ADDR_WIDTH - BANK_BITS;
    localparam int NKERNELS  = NBANKS * NPORTS;
    localparam int CID_W     = $clog2(NCONSUMERS);
    localparam int DEPTH     = READ_LATENCY + 1;

    localparam logic [CID_W:0]   NC_EXT  = (CID_W+1)'(NCONSUMERS);
    localparam logic [CID_W-1:0] LAST_ID = CID_W'(NCONSUMERS - 1);

    typedef struct packed {
        logic                   valid;
        logic                   we;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [VALUE_WIDTH-1:0] value;
    } req_t;

    typedef struct packed {
        logic                   we;
        logic [LOCAL_W-1:0]     local_addr;
        logic [VALUE_WIDTH-1:0] value;
    } cmd_t;

    typedef struct packed {
        logic             is_read;
        logic [CID_W-1:0] cid;
    } trk_t;

    if (NPORTS != 1 && NPORTS != 2) begin : g_bad_nports
        $error("rr_bank_arbiter: NPORTS must be 1 or 2");
    end
    if (NCONSUMERS < 2) begin : g_bad_nconsumers
        $error("rr_bank_arbiter: NCONSUMERS must be at least 2");
    end
    if (NBANKS < 1 || (NBANKS & (NBANKS - 1)) != 0) begin : g_bad_nbanks
        $error("rr_bank_arbiter: NBANKS must be a power of two");
    end
    if (READ_LATENCY < 1) begin : g_bad_latency
        $error("rr_bank_arbiter: READ_LATENCY must be at least 1");
    end

    function automatic logic [CID_W-1:0] next_id(input logic [CID_W-1:0] id);
        return (id == LAST_ID) ? '0 : id + CID_W'(1);
    endfunction

    // Ports of one bank start half a ring apart so they do not chase the same consumer.
    function automatic logic [CID_W-1:0] pivot_rst(input int k);
        return CID_W'(((k / NPORTS) + (k % NPORTS) * (NCONSUMERS / NPORTS)) % NCONSUMERS);
    endfunction

    req_t                  req       [NCONSUMERS];
    logic [BANK_W-1:0]     req_bank  [NCONSUMERS];
    logic [NCONSUMERS-1:0] valid_vec;

    logic [CID_W-1:0]      pivot_q   [NKERNELS];
    logic [CID_W-1:0]      pivot_d   [NKERNELS];
    logic [NKERNELS-1:0]   win_vld;
    logic [CID_W-1:0]      win_id    [NKERNELS];
    logic [NCONSUMERS-1:0] grant_w;

    cmd_t                  cmd_q     [NKERNELS];
    cmd_t                  cmd_d     [NKERNELS];
    logic [NKERNELS-1:0]   en_q;
    logic [NKERNELS-1:0]   en_d;
    trk_t                  trk_q     [NKERNELS][DEPTH];
    trk_t                  trk_d     [NKERNELS];

    logic [NCONSUMERS-1:0]  rv_w;
    logic [VALUE_WIDTH-1:0] rd_w     [NCONSUMERS];

    always_comb begin : p_decode
        for (int c = 0; c < NCONSUMERS; c++) begin
            req[c]       = req_t'(bus.requests[c]);
            req_bank[c]  = (NBANKS > 1) ? req[c].addr[BANK_W-1:0] : '0;
            valid_vec[c] = req[c].valid;
        end
    end

    // Kernels are visited bank by bank, port 0 first, so port 1 only sees consumers port 0 left over.
    always_comb begin : p_arb
        logic [NCONSUMERS-1:0]   taken;
        logic [NCONSUMERS-1:0]   elig;
        logic [2*NCONSUMERS-1:0] dbl;
        logic [NCONSUMERS-1:0]   rot;
        logic                    found;
        logic [CID_W-1:0]        off;
        logic [CID_W:0]          sum;
        int                      k;
        taken = '0;
        elig  = '0;
        dbl   = '0;
        rot   = '0;
        found = 1'b0;
        off   = '0;
        sum   = '0;
        k     = 0;
        for (int i = 0; i < NKERNELS; i++) begin
            win_vld[i] = 1'b0;
            win_id[i]  = '0;
        end
        for (int b = 0; b < NBANKS; b++) begin
            for (int p = 0; p < NPORTS; p++) begin
                k = b * NPORTS + p;
                for (int c = 0; c < NCONSUMERS; c++) begin
                    elig[c] = req[c].valid && (req_bank[c] == BANK_W'(b)) && !taken[c];
                end
                dbl   = {elig, elig};
                rot   = NCONSUMERS'(dbl >> pivot_q[k]);
                found = 1'b0;
                off   = '0;
                for (int i = 0; i < NCONSUMERS; i++) begin
                    if (!found && rot[i]) begin
                        found = 1'b1;
                        off   = CID_W'(i);
                    end
                end
                sum = {1'b0, pivot_q[k]} + {1'b0, off};
                if (sum >= NC_EXT) begin
                    sum = sum - NC_EXT;
                end
                win_vld[k] = found;
                win_id[k]  = sum[CID_W-1:0];
                if (found) begin
                    taken[sum[CID_W-1:0]] = 1'b1;
                end
            end
        end
        grant_w = taken;
    end

    always_comb begin : p_next
        for (int k = 0; k < NKERNELS; k++) begin
            cmd_d[k] = '0;
            en_d[k]  = win_vld[k];
            trk_d[k] = '0;
            if (win_vld[k]) begin
                cmd_d[k].we         = req[win_id[k]].we;
                cmd_d[k].local_addr = LOCAL_W'(req[win_id[k]].addr >> BANK_BITS);
                cmd_d[k].value      = req[win_id[k]].value;
                trk_d[k].is_read    = !req[win_id[k]].we;
                trk_d[k].cid        = win_id[k];
            end
            if (PIVOT_MODE == 0) begin
                pivot_d[k] = next_id(pivot_q[k]);
            end else begin
                pivot_d[k] = win_vld[k] ? next_id(win_id[k]) : pivot_q[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q <= '0;
            for (int k = 0; k < NKERNELS; k++) begin
                cmd_q[k]   <= '0;
                pivot_q[k] <= pivot_rst(k);
                for (int s = 0; s < DEPTH; s++) begin
                    trk_q[k][s] <= '0;
                end
            end
        end else begin
            en_q <= en_d;
            for (int k = 0; k < NKERNELS; k++) begin
                cmd_q[k]    <= cmd_d[k];
                pivot_q[k]  <= pivot_d[k];
                trk_q[k][0] <= trk_d[k];
                for (int s = 1; s < DEPTH; s++) begin
                    trk_q[k][s] <= trk_q[k][s-1];
                end
            end
        end
    end

    // A consumer wins at most one kernel per cycle, so at most one tail entry can name it.
    always_comb begin : p_resp
        trk_t tail;
        tail = '0;
        for (int c = 0; c < NCONSUMERS; c++) begin
            rv_w[c] = 1'b0;
            rd_w[c] = '0;
        end
        for (int k = 0; k < NKERNELS; k++) begin
            tail = trk_q[k][READ_LATENCY];
            if (tail.is_read) begin
                rv_w[tail.cid] = 1'b1;
                rd_w[tail.cid] = bus.plm_rdata[k];
            end
        end
    end

    always_comb begin : p_out
        bus.grant      = reset ? '0 : grant_w;
        bus.plm_en     = reset ? '0 : en_q;
        bus.resp_valid = reset ? '0 : rv_w;
        for (int k = 0; k < NKERNELS; k++) begin
            bus.out[k] = reset ? '0 : cmd_q[k];
        end
        for (int c = 0; c < NCONSUMERS; c++) begin
            bus.resp_data[c] = (reset || !rv_w[c]) ? '0 : rd_w[c];
        end
    end

    a_grant_needs_valid: assert property (@(posedge clk) disable iff (reset)
        (grant_w & ~valid_vec) == '0);

    a_grant_count: assert property (@(posedge clk) disable iff (reset)
        $countones(grant_w) == $countones(win_vld));

endmodule

// File: tb/tb_rr_bank_arbiter.sv
// Randomized and directed bench for rr_bank_arbiter: default config plus a NPORTS=1 / free-run-pivot config.
// A spec-level model (scan order, queue of pending reads with due cycles) predicts every observed output.
module tb_rr_bank_arbiter;
    localparam int AW = 4, VW = 8, NC = 4, NB = 2, RL = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_bank_arbiter_if #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC), .NBANKS(NB), .NPORTS(2)) ifa ();
    rr_bank_arbiter_if #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC), .NBANKS(NB), .NPORTS(1)) ifb ();

    rr_bank_arbiter #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC), .NBANKS(NB), .NPORTS(2),
                      .READ_LATENCY(RL), .PIVOT_MODE(1)) dut_a (.clk(clk), .reset(rst), .bus(ifa));
    rr_bank_arbiter #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC), .NBANKS(NB), .NPORTS(1),
                      .READ_LATENCY(RL), .PIVOT_MODE(0)) dut_b (.clk(clk), .reset(rst), .bus(ifb));

    typedef struct {
        int d;
        int due;
        int cid;
        int k;
    } pend_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    np    [2];
    int    pmode [2];
    bit    rv    [2][NC];
    bit    rwe   [2][NC];
    int    raddr [2][NC];
    int    rval  [2][NC];
    int    rdata [2][4];
    int    piv   [2][4];
    int    mcmd  [2][4];
    bit    men   [2][4];
    int    mwin  [2][4];
    pend_t pend  [$];

    logic [NC-1:0] exp_grant [2];
    logic [NC-1:0] obs_grant [2];
    logic [3:0]    obs_en    [2];
    logic [11:0]   obs_out   [2][4];
    logic [NC-1:0] obs_rv    [2];
    logic [7:0]    obs_rd    [2][NC];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int piv_rst(input int d, input int k);
        return (k / np[d] + (k % np[d]) * (NC / np[d])) % NC;
    endfunction

    function automatic void model_arb(input int d);
        bit taken [NC];
        int k, c;
        for (int i = 0; i < NC; i++) taken[i] = 1'b0;
        for (int b = 0; b < NB; b++) begin
            for (int p = 0; p < np[d]; p++) begin
                k = b * np[d] + p;
                mwin[d][k] = -1;
                for (int i = 0; i < NC; i++) begin
                    c = (piv[d][k] + i) % NC;
                    if (mwin[d][k] < 0 && rv[d][c] && (raddr[d][c] % NB) == b && !taken[c]) begin
                        mwin[d][k] = c;
                        taken[c]   = 1'b1;
                    end
                end
            end
        end
    endfunction

    task automatic drive();
        for (int c = 0; c < NC; c++) begin
            ifa.requests[c] = {rv[0][c], rwe[0][c], 4'(raddr[0][c]), 8'(rval[0][c])};
            ifb.requests[c] = {rv[1][c], rwe[1][c], 4'(raddr[1][c]), 8'(rval[1][c])};
        end
        for (int k = 0; k < 4; k++) ifa.plm_rdata[k] = 8'(rdata[0][k]);
        for (int k = 0; k < 2; k++) ifb.plm_rdata[k] = 8'(rdata[1][k]);
    endtask

    task automatic sample();
        obs_grant[0] = ifa.grant;
        obs_grant[1] = ifb.grant;
        obs_en[0]    = ifa.plm_en;
        obs_en[1]    = {2'b00, ifb.plm_en};
        obs_rv[0]    = ifa.resp_valid;
        obs_rv[1]    = ifb.resp_valid;
        for (int k = 0; k < 4; k++) obs_out[0][k] = ifa.out[k];
        for (int k = 0; k < 2; k++) obs_out[1][k] = ifb.out[k];
        for (int c = 0; c < NC; c++) begin
            obs_rd[0][c] = ifa.resp_data[c];
            obs_rd[1][c] = ifb.resp_data[c];
        end
    endtask

    task automatic step();
        logic [NC-1:0] e_rv;
        logic [7:0]    e_rd [NC];
        int            nk, w;
        drive();
        #4;
        sample();
        for (int d = 0; d < 2; d++) begin
            nk = NB * np[d];
            model_arb(d);
            exp_grant[d] = '0;
            if (!rst) begin
                for (int k = 0; k < nk; k++) if (mwin[d][k] >= 0) exp_grant[d][mwin[d][k]] = 1'b1;
            end
            check($sformatf("gnt d%0d cyc%0d", d, cyc), 32'(obs_grant[d]), 32'(exp_grant[d]));
            for (int k = 0; k < nk; k++) begin
                check($sformatf("out d%0d k%0d cyc%0d", d, k, cyc), 32'(obs_out[d][k]), rst ? 32'd0 : 32'(mcmd[d][k]));
                check($sformatf("en d%0d k%0d cyc%0d", d, k, cyc), 32'(obs_en[d][k]), rst ? 32'd0 : 32'(men[d][k]));
            end
            e_rv = '0;
            for (int c = 0; c < NC; c++) e_rd[c] = '0;
            if (!rst) begin
                foreach (pend[i]) begin
                    if (pend[i].d == d && pend[i].due == cyc) begin
                        e_rv[pend[i].cid] = 1'b1;
                        e_rd[pend[i].cid] = 8'(rdata[d][pend[i].k]);
                    end
                end
            end
            check($sformatf("rv d%0d cyc%0d", d, cyc), 32'(obs_rv[d]), 32'(e_rv));
            for (int c = 0; c < NC; c++)
                check($sformatf("rd d%0d c%0d cyc%0d", d, c, cyc), 32'(obs_rd[d][c]), 32'(e_rd[c]));
        end
        for (int d = 0; d < 2; d++) begin
            nk = NB * np[d];
            for (int k = 0; k < nk; k++) begin
                w = mwin[d][k];
                if (rst) begin
                    piv[d][k]  = piv_rst(d, k);
                    mcmd[d][k] = 0;
                    men[d][k]  = 1'b0;
                end else begin
                    if (w >= 0) begin
                        mcmd[d][k] = (int'(rwe[d][w]) << 11) | ((raddr[d][w] / NB) << 8) | rval[d][w];
                        men[d][k]  = 1'b1;
                        if (!rwe[d][w]) pend.push_back('{d, cyc + 1 + RL, w, k});
                    end else begin
                        mcmd[d][k] = 0;
                        men[d][k]  = 1'b0;
                    end
                    if (pmode[d] == 1) begin
                        if (w >= 0) piv[d][k] = (w + 1) % NC;
                    end else begin
                        piv[d][k] = (piv[d][k] + 1) % NC;
                    end
                end
            end
        end
        for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].due <= cyc || rst) pend.delete(i);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NC; c++) begin
                rv[d][c] = 1'b0; rwe[d][c] = 1'b0; raddr[d][c] = 0; rval[d][c] = 0;
            end
    endtask

    task automatic set_req(input int d, input int c, input bit we, input int addr, input int val);
        rv[d][c] = 1'b1; rwe[d][c] = we; raddr[d][c] = addr; rval[d][c] = val;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic check_pivots_a(input string tag);
        int exp_p [4];
        exp_p = '{0, 2, 1, 3};
        for (int k = 0; k < 4; k++)
            check($sformatf("%s piv a k%0d", tag, k), 32'(dut_a.pivot_q[k]), 32'(exp_p[k]));
    endtask

    initial begin
        np[0] = 2; np[1] = 1;
        pmode[0] = 1; pmode[1] = 0;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) begin
                rdata[d][k] = 0; mcmd[d][k] = 0; men[d][k] = 1'b0; mwin[d][k] = -1;
                piv[d][k] = (k < NB * np[d]) ? piv_rst(d, k) : 0;
            end
        clear_reqs();
        rst = 1'b1;
        drive();
        @(posedge clk);
        #1;

        do_reset(2);
        check_pivots_a("reset");
        check("reset piv b k0", 32'(dut_b.pivot_q[0]), 32'd0);
        check("reset piv b k1", 32'(dut_b.pivot_q[1]), 32'd1);

        // all four consumers read bank 0
        for (int c = 0; c < NC; c++) set_req(0, c, 1'b0, 0, c);
        step(); check("t1 gnt cyc0", 32'(obs_grant[0]), 32'h5);
        step(); check("t1 gnt cyc1", 32'(obs_grant[0]), 32'hA);
        check("t1 out0", 32'(obs_out[0][0]), 32'h000);
        check("t1 out1", 32'(obs_out[0][1]), 32'h002);
        check("t1 en", 32'(obs_en[0]), 32'h3);
        step(); check("t1 gnt cyc2", 32'(obs_grant[0]), 32'h5);
        clear_reqs();
        repeat (3) step();

        // single read to bank 1 with returned data
        do_reset(1);
        set_req(0, 1, 1'b0, 5, 0);
        rdata[0][2] = 8'hA5;
        step(); check("t2 gnt", 32'(obs_grant[0]), 32'h2);
        clear_reqs();
        step(); check("t2 out2", 32'(obs_out[0][2]), 32'h200);
        check("t2 en", 32'(obs_en[0]), 32'h4);
        check("t2 rv early", 32'(obs_rv[0]), 32'h0);
        step(); check("t2 rv", 32'(obs_rv[0]), 32'h2);
        check("t2 rd", 32'(obs_rd[0][1]), 32'hA5);
        step(); check("t2 rv late", 32'(obs_rv[0]), 32'h0);

        // write produces a command but no response
        do_reset(1);
        set_req(0, 3, 1'b1, 3, 8'h5C);
        step(); check("t3 gnt", 32'(obs_grant[0]), 32'h8);
        clear_reqs();
        step(); check("t3 out2", 32'(obs_out[0][2]), 32'h95C);
        check("t3 en", 32'(obs_en[0]), 32'h4);
        step(); check("t3 rv a", 32'(obs_rv[0]), 32'h0);
        step(); check("t3 rv b", 32'(obs_rv[0]), 32'h0);

        // free-running pivot, single port per bank
        do_reset(1);
        set_req(1, 2, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t4 piv b step%0d", i), 32'(dut_b.pivot_q[0]), 32'(i));
            step();
            check($sformatf("t4 gnt b step%0d", i), 32'(obs_grant[1]), 32'h4);
        end
        check("t4 piv b end", 32'(dut_b.pivot_q[0]), 32'd3);
        clear_reqs();

        // reset mid-flight drops the read
        do_reset(1);
        set_req(0, 0, 1'b0, 0, 0);
        step(); check("t5 gnt", 32'(obs_grant[0]), 32'h1);
        clear_reqs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_pivots_a("t5");
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t5 rv step%0d", i), 32'(obs_rv[0]), 32'h0);
        end

        // idle: nothing issued, pivots hold
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("t6 en step%0d", i), 32'(obs_en[0]), 32'h0);
            check($sformatf("t6 out2 step%0d", i), 32'(obs_out[0][2]), 32'h0);
        end
        check_pivots_a("t6");

        // random traffic, requests held until granted
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < NC; c++) begin
                    if (!rv[d][c] || exp_grant[d][c]) begin
                        rv[d][c]    = ($urandom_range(0, 99) < 70);
                        rwe[d][c]   = ($urandom_range(0, 2) == 0);
                        raddr[d][c] = $urandom_range(0, 15);
                        rval[d][c]  = $urandom_range(0, 255);
                    end
                end
                for (int k = 0; k < 4; k++) rdata[d][k] = $urandom_range(0, 255);
            end
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
